// File: rtl/ahbl2obi_bridge.sv
// AHB-Lite subordinate to OBI manager bridge: one single transfer in flight, min 2 wait states.
// OBI gnt/rvalid stalls hold HREADYOUT low; bad size/alignment or r.err gives a two-cycle ERROR.
package ahbl2obi_pkg;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned IdWidth   = 1;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic [IdWidth-1:0]     aid;
    logic                   a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } obi_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [IdWidth-1:0]   rid;
    logic                 err;
    logic                 r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;
endpackage

module ahbl2obi_bridge #(
  parameter type obi_req_t = ahbl2obi_pkg::obi_req_t,
  parameter type obi_rsp_t = ahbl2obi_pkg::obi_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output obi_req_t    obi_req_o,
  input  obi_rsp_t    obi_rsp_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR1, S_ERR2
  } state_e;

  state_e      state, state_nxt;
  logic        addr_open, accept, legal;
  logic [31:0] addr_q;
  logic        we_q;
  logic [2:0]  size_q;
  logic [3:0]  be;
  logic        req_q, hreadyout_q, hresp_q;
  logic [31:0] hrdata_q;
  logic        unused_bits;

  assign unused_bits = ^{obi_rsp_i.r.rid, obi_rsp_i.r.r_optional, HTRANS[0]};

  // DONE and ERR2 take a new address phase exactly like IDLE (pipelined accept)
  assign addr_open = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);
  assign accept    = addr_open & HSEL & HREADY & HTRANS[1];

  always_comb begin
    legal = 1'b0;
    case (HSIZE)
      3'd0:    legal = 1'b1;
      3'd1:    legal = ~HADDR[0];
      3'd2:    legal = (HADDR[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    be = 4'b1111;
    case (size_q)
      3'd0:    be = 4'b0001 << addr_q[1:0];
      3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) state_nxt = legal ? S_REQ : S_ERR1;
        else        state_nxt = S_IDLE;
      end
      S_REQ:  if (obi_rsp_i.gnt) state_nxt = S_WAIT;
      S_WAIT: if (obi_rsp_i.rvalid) state_nxt = obi_rsp_i.r.err ? S_ERR1 : S_DONE;
      S_ERR1: state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are glitch-free Moore values
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      req_q       <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
    end else begin
      state       <= state_nxt;
      req_q       <= (state_nxt == S_REQ);
      hreadyout_q <= (state_nxt == S_IDLE) || (state_nxt == S_DONE) || (state_nxt == S_ERR2);
      hresp_q     <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
      if (accept) begin
        addr_q <= HADDR;
        we_q   <= HWRITE;
        size_q <= HSIZE;
      end
      if ((state == S_WAIT) && obi_rsp_i.rvalid && !obi_rsp_i.r.err && !we_q)
        hrdata_q <= obi_rsp_i.r.rdata;
    end
  end

  always_comb begin
    obi_req_o = '0;
    if (req_q) begin
      obi_req_o.req     = 1'b1;
      obi_req_o.a.addr  = addr_q;
      obi_req_o.a.we    = we_q;
      obi_req_o.a.be    = be;
      obi_req_o.a.wdata = HWDATA;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

endmodule
